mem_access_unit: RTL and testbench

Load/store sequencer between the multi-cycle datapath and the byte-addressed, word-wide data memory. It accepts one load or store request at a time and handles byte, halfword and word sizes. Loads read the aligned word and extract and extend the addressed lane. Sub-word stores do a read-modify-write, because the memory always writes all four bytes. It drives the memory's `adr`/`d_in`/`mrd`/`mwr` pins and consumes its combinational `d_out`.

---
 rtl/mips_mem_pkg.sv | 27 ++
 rtl/byte_lane_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the load/store sequencer and its lane aligner.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Reserved size 2'b11 is reported as misaligned so it takes the error path.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module byte_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign shamt   = {addr_lo_i, 3'b000};
  assign shifted = word_i >> shamt;

  always_comb begin
    load_o = word_i;
    mask   = '1;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
        mask   = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        load_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
        mask   = 32'h0000_FFFF << shamt;
      end
      default: begin
        load_o = word_i;
        mask   = '1;
      end
    endcase
    // Word size collapses to a full-mask merge, i.e. plain wdata.
    merge_o = (word_i & ~mask) | ((wdata_i << shamt) & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request at a time, read-modify-write for sub-word stores.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_d_in,
  output logic              mem_mrd,
  output logic              mem_mwr,
  input  logic [31:0]       mem_d_out
);

  state_t              state_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                sext_q;
  logic [1:0]          addr_lo_q;
  logic [31:0]         wdata_q;
  logic [31:0]         buf_q;
  logic [31:0]         rdata_q;
  logic                busy_q, done_q, err_q, mrd_q, mwr_q;
  logic [ADDR_W-1:0]   mem_adr_q;

  logic [31:0] align_word;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Extraction sees live memory data during READ; the merge uses the buffered word in WRITE.
  assign align_word = (state_q == ST_READ) ? mem_d_out : buf_q;

  byte_lane_align u_align (
    .word_i     (align_word),
    .addr_lo_i  (addr_lo_q),
    .size_i     (size_q),
    .sign_ext_i (sext_q),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merge_o    (merge_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      addr_lo_q <= '0;
      wdata_q   <= '0;
      buf_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mrd_q     <= 1'b0;
      mwr_q     <= 1'b0;
      mem_adr_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      mrd_q  <= 1'b0;
      mwr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (req) begin
            we_q      <= we;
            size_q    <= size;
            sext_q    <= sign_ext;
            addr_lo_q <= addr[1:0];
            wdata_q   <= wdata;
            mem_adr_q <= {addr[ADDR_W-1:2], 2'b00};
            busy_q    <= 1'b1;
            if (misaligned(size, addr[1:0])) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (we && (size == SZ_WORD)) begin
              state_q <= ST_WRITE;
              mwr_q   <= 1'b1;
            end else begin
              state_q <= ST_READ;
              mrd_q   <= 1'b1;
            end
          end
        end
        ST_READ: begin
          buf_q <= mem_d_out;
          if (!we_q) begin
            rdata_q <= load_val;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_WRITE;
            mwr_q   <= 1'b1;
          end
        end
        ST_WRITE: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign mem_adr  = mem_adr_q;
  assign mem_mrd  = mrd_q;
  assign mem_mwr  = mwr_q;
  assign mem_d_in = (state_q == ST_WRITE) ? merge_val : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a combinational-read word memory model.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [31:0] mem_adr;
  logic [31:0] mem_d_in;
  logic        mem_mrd, mem_mwr;
  logic [31:0] mem_d_out;

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_both = 0;
  int rb, wb;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_adr   (mem_adr),
    .mem_d_in  (mem_d_in),
    .mem_mrd   (mem_mrd),
    .mem_mwr   (mem_mwr),
    .mem_d_out (mem_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_d_out = mem[mem_adr[9:2]];

  always @(posedge clk) begin
    if (mem_mwr) mem[mem_adr[9:2]] <= mem_d_in;
  end

  always @(negedge clk) begin
    if (mem_mrd) n_rd++;
    if (mem_mwr) n_wr++;
    if (mem_mrd && mem_mwr) n_both++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request so that it is accepted at the next rising edge; returns 1ns after it.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [31:0] exp);
    rb = n_rd; wb = n_wr;
    issue(1'b0, sz, sx, a, 32'h0);
    chk1({tag, "_mrd"}, mem_mrd, 1'b1);
    chk1({tag, "_done_early"}, done, 1'b0);
    step();
    chk1({tag, "_done"}, done, 1'b1);
    chk1({tag, "_err"}, err, 1'b0);
    chk({tag, "_rdata"}, rdata, exp);
    step();
    chk1({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_rdcnt"}, n_rd - rb, 32'd1);
    chk({tag, "_wrcnt"}, n_wr - wb, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'hA1B2C3D4;
    rst = 1'b0; req = 1'b0; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_mrd", mem_mrd, 1'b0);
    chk1("rst_mwr", mem_mwr, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_adr", mem_adr, 32'h0);
    chk("rst_din", mem_d_in, 32'h0);
    rst = 1'b1;

    // Signed byte load with address check on the READ cycle
    rb = n_rd; wb = n_wr;
    issue(1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0);
    chk1("ldsb_mrd", mem_mrd, 1'b1);
    chk1("ldsb_busy", busy, 1'b1);
    chk("ldsb_adr", mem_adr, 32'h100);
    step();
    chk1("ldsb_done", done, 1'b1);
    chk1("ldsb_mrd_off", mem_mrd, 1'b0);
    chk("ldsb_rdata", rdata, 32'hFFFFFFA1);
    step();
    chk1("ldsb_idle_done", done, 1'b0);
    chk1("ldsb_idle_busy", busy, 1'b0);
    chk("ldsb_wrcnt", n_wr - wb, 32'd0);

    do_load("ldub", 32'h102, SZ_BYTE, 1'b0, 32'h000000B2);
    do_load("ldsh", 32'h102, SZ_HALF, 1'b1, 32'hFFFFA1B2);
    do_load("lduh", 32'h100, SZ_HALF, 1'b0, 32'h0000C3D4);

    // Byte store: read-modify-write
    rb = n_rd; wb = n_wr;
    issue(1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h00000055);
    chk1("sb_mrd", mem_mrd, 1'b1);
    chk1("sb_mwr0", mem_mwr, 1'b0);
    step();
    chk1("sb_mwr", mem_mwr, 1'b1);
    chk1("sb_mrd_off", mem_mrd, 1'b0);
    chk("sb_din", mem_d_in, 32'hA1B255D4);
    chk1("sb_done_early", done, 1'b0);
    step();
    chk1("sb_done", done, 1'b1);
    chk1("sb_err", err, 1'b0);
    chk("sb_rdata_hold", rdata, 32'h0000C3D4);
    step();
    chk("sb_mem", mem[64], 32'hA1B255D4);
    chk("sb_rdcnt", n_rd - rb, 32'd1);
    chk("sb_wrcnt", n_wr - wb, 32'd1);
    do_load("lw_after_sb", 32'h100, SZ_WORD, 1'b1, 32'hA1B255D4);

    // Word store: single write cycle
    rb = n_rd; wb = n_wr;
    issue(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h12345678);
    chk1("sw_mwr", mem_mwr, 1'b1);
    chk1("sw_mrd", mem_mrd, 1'b0);
    chk("sw_din", mem_d_in, 32'h12345678);
    step();
    chk1("sw_done", done, 1'b1);
    chk1("sw_mwr_off", mem_mwr, 1'b0);
    step();
    chk("sw_rdcnt", n_rd - rb, 32'd0);
    chk("sw_wrcnt", n_wr - wb, 32'd1);
    do_load("lw_after_sw", 32'h100, SZ_WORD, 1'b0, 32'h12345678);

    // Upper half store; upper wdata bits must be ignored
    issue(1'b1, SZ_HALF, 1'b0, 32'h102, 32'hCAFEBEEF);
    step();
    chk("sh_din", mem_d_in, 32'hBEEF5678);
    step();
    chk1("sh_done", done, 1'b1);
    step();
    chk("sh_mem", mem[64], 32'hBEEF5678);
    do_load("ldsb_pos", 32'h101, SZ_BYTE, 1'b1, 32'h00000056);

    // Misaligned half store with req held high into the DONE cycle
    rb = n_rd; wb = n_wr;
    @(negedge clk);
    we = 1'b1; size = SZ_HALF; sign_ext = 1'b0; addr = 32'h101; wdata = 32'hFFFF; req = 1'b1;
    step();
    chk1("mis_done", done, 1'b1);
    chk1("mis_err", err, 1'b1);
    chk1("mis_busy", busy, 1'b1);
    chk1("mis_mrd", mem_mrd, 1'b0);
    chk1("mis_mwr", mem_mwr, 1'b0);
    we = 1'b0; size = SZ_WORD; addr = 32'h100;
    step();
    chk1("held_idle_busy", busy, 1'b0);
    chk1("held_idle_mrd", mem_mrd, 1'b0);
    chk1("held_idle_err", err, 1'b0);
    step();
    req = 1'b0;
    chk1("held_accept_mrd", mem_mrd, 1'b1);
    step();
    chk1("held_done", done, 1'b1);
    chk("held_rdata", rdata, 32'hBEEF5678);
    step();
    chk("mis_wrcnt", n_wr - wb, 32'd0);

    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    chk1("rsv_err", err, 1'b1);
    chk1("rsv_mrd", mem_mrd, 1'b0);
    step();
    issue(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0);
    chk1("misw_err", err, 1'b1);
    chk1("misw_done", done, 1'b1);
    step();

    // Reset during the READ of a byte store abandons it
    wb = n_wr;
    issue(1'b1, SZ_BYTE, 1'b0, 32'h100, 32'h00000099);
    chk1("rstrd_mrd", mem_mrd, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("rstrd_busy", busy, 1'b0);
    chk1("rstrd_mrd", mem_mrd, 1'b0);
    chk1("rstrd_mwr", mem_mwr, 1'b0);
    chk1("rstrd_done", done, 1'b0);
    chk("rstrd_rdata", rdata, 32'h0);
    chk("rstrd_adr", mem_adr, 32'h0);
    chk("rstrd_din", mem_d_in, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();
    chk("rstrd_wrcnt", n_wr - wb, 32'd0);
    chk("rstrd_mem", mem[64], 32'hBEEF5678);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h100, 32'h00000099);
    step();
    chk("post_rst_din", mem_d_in, 32'hBEEF5699);
    step();
    chk1("post_rst_done", done, 1'b1);
    step();
    do_load("lw_post_rst", 32'h100, SZ_WORD, 1'b0, 32'hBEEF5699);

    chk("mrd_mwr_excl", n_both, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
